// File: rtl/ram_dp_param.sv
// Simple dual-port RAM with byte enables, selectable read-during-write mode and a clear sequencer.
// Read latency 1 cycle (rd_valid pulse); no backpressure, and all port activity is ignored while busy.
module ram_dp_param #(
  parameter int                DATA_W  = 16,
  parameter int                ADDR_W  = 4,
  parameter int                DEPTH   = 16,
  parameter int                RD_MODE = 0,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_req,
  output logic                busy,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid
);

  localparam int NB = DATA_W / 8;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_ptr;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_valid;

  logic                w_idle;
  logic                w_clr_last;
  logic                w_wr_in_rng;
  logic                w_rd_in_rng;
  logic                w_wr_do;
  logic                w_rd_do;
  logic                w_collide;
  logic [DATA_W-1:0]   w_wr_old;
  logic [DATA_W-1:0]   w_wr_merged;
  logic [DATA_W-1:0]   w_rd_word;
  logic [DATA_W-1:0]   w_rd_next;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_clr_last  = (r_clr_ptr == ADDR_W'(DEPTH - 1));
  assign w_wr_in_rng = ({1'b0, wr_addr} < (ADDR_W + 1)'(DEPTH));
  assign w_rd_in_rng = ({1'b0, rd_addr} < (ADDR_W + 1)'(DEPTH));

  // Out-of-range addresses never touch the array: writes drop, reads see zero.
  assign w_wr_old  = w_wr_in_rng ? r_mem[wr_addr] : '0;
  assign w_rd_word = w_rd_in_rng ? r_mem[rd_addr] : '0;

  always_comb begin
    w_wr_merged = w_wr_old;
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) begin
        w_wr_merged[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  end

  assign w_wr_do   = w_idle & wr_en & w_wr_in_rng & (|wr_be);
  assign w_rd_do   = w_idle & rd_en;
  assign w_collide = wr_en & w_wr_in_rng & (wr_addr == rd_addr);
  assign w_rd_next = ((RD_MODE != 0) && w_collide) ? w_wr_merged : w_rd_word;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (clr_req)    w_state_nxt = ST_CLEAR;
      ST_CLEAR: if (w_clr_last) w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (r_state == ST_CLEAR);
  end

  // Pointer parks at zero outside CLEAR so a new request always starts at word 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_ptr <= '0;
    end else if ((r_state == ST_CLEAR) && !w_clr_last) begin
      r_clr_ptr <= r_clr_ptr + 1'b1;
    end else begin
      r_clr_ptr <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clr_ptr] <= CLR_VAL;
    end else if (w_wr_do) begin
      r_mem[wr_addr] <= w_wr_merged;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_do;
      if (w_rd_do) begin
        r_rd_data <= w_rd_next;
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_ram_dp_param.sv
// Directed bench for ram_dp_param: instance a is read-first (defaults), instance b is
// write-first with DEPTH=12 and CLR_VAL=0xDEAD; both share one stimulus stream.
module tb_ram_dp_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_req = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_be = '0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = '0;

  logic        a_busy, a_rd_valid, b_busy, b_rd_valid;
  logic [15:0] a_rd_data, b_rd_data;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] sc_a [16];
  logic [15:0] sc_b [16];

  ram_dp_param u_dut_a (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(a_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid)
  );

  ram_dp_param #(
    .DATA_W(16), .ADDR_W(4), .DEPTH(12), .RD_MODE(1), .CLR_VAL(16'hDEAD)
  ) u_dut_b (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(b_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic [1:0] be, input logic re, input logic [3:0] ra);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en = re; rd_addr = ra;
    tick();
  endtask

  task automatic model_wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    for (int i = 0; i < 2; i++) begin
      if (be[i]) begin
        sc_a[a][8*i +: 8] = d[8*i +: 8];
        if (a < 12) sc_b[a][8*i +: 8] = d[8*i +: 8];
      end
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    drive(1'b1, a, d, be, 1'b0, 4'd0);
    model_wr(a, d, be);
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [15:0] ea, input logic [15:0] eb);
    drive(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, a);
    chk({tag, "_vld_a"}, a_rd_valid, 1);
    chk({tag, "_dat_a"}, a_rd_data, ea);
    chk({tag, "_vld_b"}, b_rd_valid, 1);
    chk({tag, "_dat_b"}, b_rd_data, eb);
  endtask

  // Busy is already observed high once by the caller; count the remaining busy cycles.
  task automatic measure_busy(input string tag, input logic [15:0] hold_a, input logic [15:0] hold_b);
    int la = 1;
    int lb = 1;
    bit da = 1'b0;
    bit db = 1'b0;
    for (int k = 0; k < 40 && !(da && db); k++) begin
      tick();
      if (!da) begin
        if (a_busy) begin
          la++;
          chk({tag, "_vld_a"}, a_rd_valid, 0);
          chk({tag, "_hold_a"}, a_rd_data, hold_a);
        end else da = 1'b1;
      end
      if (!db) begin
        if (b_busy) begin
          lb++;
          chk({tag, "_vld_b"}, b_rd_valid, 0);
          chk({tag, "_hold_b"}, b_rd_data, hold_b);
        end else db = 1'b1;
      end
    end
    chk({tag, "_len_a"}, da ? la : 0, 16);
    chk({tag, "_len_b"}, db ? lb : 0, 12);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    logic [15:0] hold_a, hold_b;
    int vrun;

    for (int i = 0; i < 16; i++) begin
      sc_a[i] = 16'h0000;
      sc_b[i] = (i < 12) ? 16'hDEAD : 16'h0000;
    end

    // Reset for two cycles, then the power-up clear
    tick(); tick();
    chk("rst_busy_a", a_busy, 1);
    chk("rst_busy_b", b_busy, 1);
    chk("rst_vld_a", a_rd_valid, 0);
    chk("rst_dat_a", a_rd_data, 0);
    chk("rst_vld_b", b_rd_valid, 0);
    chk("rst_dat_b", b_rd_data, 0);
    rst = 1'b0;
    measure_busy("init_clr", 16'h0, 16'h0);

    for (int i = 0; i < 16; i++)
      rd($sformatf("clr_rd%0d", i), 4'(i), 16'h0000, (i < 12) ? 16'hDEAD : 16'h0000);
    drive(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0);
    chk("idle_vld_a", a_rd_valid, 0);
    chk("idle_hold_a", a_rd_data, 16'h0000);
    chk("idle_vld_b", b_rd_valid, 0);

    // Byte enables
    wr(4'd3, 16'hA5A5, 2'b11);
    wr(4'd3, 16'h1234, 2'b01);
    rd("be_lo", 4'd3, 16'hA534, 16'hA534);
    wr(4'd3, 16'hFFFF, 2'b00);
    rd("be_none", 4'd3, 16'hA534, 16'hA534);

    // Read-during-write collisions: a read-first, b write-first
    wr(4'd7, 16'h1111, 2'b11);
    drive(1'b1, 4'd7, 16'h2222, 2'b11, 1'b1, 4'd7);
    model_wr(4'd7, 16'h2222, 2'b11);
    chk("col_full_vld_a", a_rd_valid, 1);
    chk("col_full_dat_a", a_rd_data, 16'h1111);
    chk("col_full_dat_b", b_rd_data, 16'h2222);
    rd("col_after", 4'd7, 16'h2222, 16'h2222);
    drive(1'b1, 4'd7, 16'h33CC, 2'b01, 1'b1, 4'd7);
    model_wr(4'd7, 16'h33CC, 2'b01);
    chk("col_part_dat_a", a_rd_data, 16'h2222);
    chk("col_part_dat_b", b_rd_data, 16'h22CC);
    rd("col_part_after", 4'd7, 16'h22CC, 16'h22CC);

    // Fill and back-to-back readback
    for (int i = 0; i < 16; i++) begin
      v = 16'($urandom);
      wr(4'(i), v, 2'b11);
    end
    vrun = 0;
    for (int i = 0; i < 16; i++) begin
      rd($sformatf("fill_rd%0d", i), 4'(i), sc_a[i], sc_b[i]);
      if (a_rd_valid) vrun++;
    end
    chk("fill_vld_run", vrun, 16);
    drive(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0);
    chk("fill_idle_vld_a", a_rd_valid, 0);
    chk("fill_idle_hold_a", a_rd_data, sc_a[15]);
    chk("fill_idle_hold_b", b_rd_data, 16'h0000);

    // Out-of-range for b (DEPTH=12), in range for a
    wr(4'd13, 16'hBEEF, 2'b11);
    rd("oor13", 4'd13, 16'hBEEF, 16'h0000);
    rd("oor_alias1", 4'd1, sc_a[1], sc_b[1]);
    hold_a = sc_a[1];
    hold_b = sc_b[1];

    // clr_req with writes/reads hammering addr 14 while busy
    clr_req = 1'b1;
    drive(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0);
    clr_req = 1'b0;
    chk("creq_busy_a", a_busy, 1);
    chk("creq_busy_b", b_busy, 1);
    chk("creq_vld_a", a_rd_valid, 0);
    wr_en = 1'b1; wr_addr = 4'd14; wr_data = 16'h5555; wr_be = 2'b11;
    rd_en = 1'b1; rd_addr = 4'd14;
    measure_busy("creq", hold_a, hold_b);
    drive(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0);
    for (int i = 0; i < 16; i++) begin
      sc_a[i] = 16'h0000;
      sc_b[i] = (i < 12) ? 16'hDEAD : 16'h0000;
    end
    for (int i = 0; i < 16; i++)
      rd($sformatf("creq_rd%0d", i), 4'(i), sc_a[i], sc_b[i]);

    // Reset in the middle of a clear restarts it from word 0
    wr(4'd5, 16'h7777, 2'b11);
    clr_req = 1'b1;
    drive(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0);
    clr_req = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_busy_a", a_busy, 1);
    chk("mid_rst_dat_a", a_rd_data, 16'h0000);
    chk("mid_rst_dat_b", b_rd_data, 16'h0000);
    chk("mid_rst_vld_b", b_rd_valid, 0);
    tick();
    rst = 1'b0;
    measure_busy("mid_rst", 16'h0, 16'h0);
    rd("mid_rd0", 4'd0, 16'h0000, 16'hDEAD);
    rd("mid_rd5", 4'd5, 16'h0000, 16'hDEAD);
    rd("mid_rd11", 4'd11, 16'h0000, 16'hDEAD);
    rd("mid_rd15", 4'd15, 16'h0000, 16'h0000);
    drive(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
